// File: rtl/dog_hit_detect_pkg.sv
// Shared game constants for the dog sprite box and ground line, plus the
// dog hit FSM state type used by dog_hit_detect.
package dog_hit_detect_pkg;

  localparam int unsigned DOG_X    = 880;
  localparam int unsigned DOG_Y    = 430;
  localparam int unsigned DOG_W    = 140;
  localparam int unsigned DOG_H    = 151;
  localparam int unsigned GROUND_Y = DOG_Y + DOG_H;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned SUM_W   = 12;

  typedef enum logic {
    ARMED   = 1'b0,
    LOCKOUT = 1'b1
  } dog_state_e;

  // Half-open box overlap of a projectile box against the dog box, all at 12 bits.
  function automatic logic box_overlap(input logic [COORD_W-1:0] px,
                                       input logic [COORD_W-1:0] py,
                                       input logic [SUM_W-1:0]   pw,
                                       input logic [SUM_W-1:0]   ph);
    logic [SUM_W-1:0] px_w;
    logic [SUM_W-1:0] py_w;
    px_w = {1'b0, px};
    py_w = {1'b0, py};
    return (px_w < SUM_W'(DOG_X + DOG_W)) && ((px_w + pw) > SUM_W'(DOG_X)) &&
           (py_w < SUM_W'(DOG_Y + DOG_H)) && ((py_w + ph) > SUM_W'(DOG_Y));
  endfunction

endpackage

// File: rtl/dog_hit_detect_frame_tick_gen.sv
// Frame tick generator: one-cycle pulse in the first cycle vblnk is seen
// high after being low.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_q;
  logic vblnk_d;

  always_comb begin
    vblnk_d = vblnk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk_d;
    end
  end

  assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/dog_hit_detect.sv
// Per-frame cat projectile vs dog box hit detector with frame lockout.
// Optional miss reporting (proj_miss) is enabled by DOG_HIT_MISS_REPORT_EN.
module dog_hit_detect
  import dog_hit_detect_pkg::*;
#(
  parameter int unsigned PROJ_W         = 24,
  parameter int unsigned PROJ_H         = 24,
  parameter int unsigned LOCKOUT_FRAMES = 30,
  parameter int unsigned HIT_CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vblnk,
  input  logic [10:0]          proj_x,
  input  logic [10:0]          proj_y,
  input  logic                 proj_valid,
  output logic                 hit_dog,
  output logic                 proj_kill,
  output logic [HIT_CNT_W-1:0] hit_count,
  output logic                 locked
`ifdef DOG_HIT_MISS_REPORT_EN
  ,
  output logic                 proj_miss
`endif
);

  localparam int unsigned CNT_W = (LOCKOUT_FRAMES > 1) ? $clog2(LOCKOUT_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOCKOUT_FRAMES);
  localparam logic [SUM_W-1:0] PW = SUM_W'(PROJ_W);
  localparam logic [SUM_W-1:0] PH = SUM_W'(PROJ_H);

  logic tick;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (tick)
  );

  logic [COORD_W-1:0]   snap_x_q, snap_x_d;
  logic [COORD_W-1:0]   snap_y_q, snap_y_d;
  logic                 snap_vld_q, snap_vld_d;
  logic                 stb_q, stb_d;
  logic                 eval_q, eval_d;
  logic                 hit_q, hit_d;
  logic                 kill_q, kill_d;
  logic                 miss_q, miss_d;
  dog_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic                 overlap;

  always_comb begin
    snap_x_d   = tick ? proj_x : snap_x_q;
    snap_y_d   = tick ? proj_y : snap_y_q;
    snap_vld_d = tick ? proj_valid : snap_vld_q;
    stb_d      = tick;
    eval_d     = tick & (state_q == ARMED);

    overlap = box_overlap(snap_x_q, snap_y_q, PW, PH);
    hit_d   = stb_q & eval_q & snap_vld_q & overlap;
`ifdef DOG_HIT_MISS_REPORT_EN
    miss_d  = stb_q & snap_vld_q & ~hit_d &
              (({1'b0, snap_y_q} + PH) >= SUM_W'(GROUND_Y));
`else
    miss_d  = 1'b0;
`endif
    kill_d  = hit_d | miss_d;

    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      ARMED: begin
        if (hit_d) begin
          state_d = LOCKOUT;
          cnt_d   = CNT_INIT;
          if (hit_cnt_q != '1) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
      end
      LOCKOUT: begin
        // A counter of 1 reaches zero on this tick; 0 only occurs with LOCKOUT_FRAMES=0.
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_vld_q <= 1'b0;
      stb_q      <= 1'b0;
      eval_q     <= 1'b0;
      hit_q      <= 1'b0;
      kill_q     <= 1'b0;
      miss_q     <= 1'b0;
      state_q    <= ARMED;
      cnt_q      <= '0;
      hit_cnt_q  <= '0;
    end else begin
      snap_x_q   <= snap_x_d;
      snap_y_q   <= snap_y_d;
      snap_vld_q <= snap_vld_d;
      stb_q      <= stb_d;
      eval_q     <= eval_d;
      hit_q      <= hit_d;
      kill_q     <= kill_d;
      miss_q     <= miss_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  assign hit_dog   = hit_q;
  assign proj_kill = kill_q;
  assign hit_count = hit_cnt_q;
  assign locked    = (state_q == LOCKOUT);
`ifdef DOG_HIT_MISS_REPORT_EN
  assign proj_miss = miss_q;
`else
  logic unused_miss;
  assign unused_miss = miss_q;
`endif

endmodule

// File: tb/tb_dog_hit_detect.sv
// Scoreboard bench for dog_hit_detect: per-frame expectations from a
// behavioural model, checked by an independent monitor two cycles after each tick.
module tb_dog_hit_detect;
  import dog_hit_detect_pkg::*;

  localparam int LOCK = 30;
  localparam int PW   = 24;
  localparam int PH   = 24;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          vblnk;
  logic [10:0]   proj_x;
  logic [10:0]   proj_y;
  logic          proj_valid;
  logic          hit_dog;
  logic          proj_kill;
  logic [CW-1:0] hit_count;
  logic          locked;
`ifdef DOG_HIT_MISS_REPORT_EN
  logic          proj_miss;
`endif

  dog_hit_detect #(
    .PROJ_W         (PW),
    .PROJ_H         (PH),
    .LOCKOUT_FRAMES (LOCK),
    .HIT_CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .proj_x     (proj_x),
    .proj_y     (proj_y),
    .proj_valid (proj_valid),
    .hit_dog    (hit_dog),
    .proj_kill  (proj_kill),
    .hit_count  (hit_count),
    .locked     (locked)
`ifdef DOG_HIT_MISS_REPORT_EN
    ,
    .proj_miss  (proj_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    bit kill;
    bit miss;
    int cnt;
    bit lck;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Behavioural model: armed flag, frames still to ignore, hit tally.
  bit m_armed;
  int m_ignore;
  int m_cnt;

  task automatic model_reset();
    m_armed  = 1'b1;
    m_ignore = 0;
    m_cnt    = 0;
  endtask

  function automatic bit overlaps(int px, int py);
    return (px < int'(DOG_X + DOG_W)) && (px + PW > int'(DOG_X)) &&
           (py < int'(DOG_Y + DOG_H)) && (py + PH > int'(DOG_Y));
  endfunction

  task automatic model_tick(input int px, input int py, input bit v, output exp_t e);
    e.hit  = m_armed && v && overlaps(px, py);
`ifdef DOG_HIT_MISS_REPORT_EN
    e.miss = v && !e.hit && (py + PH >= int'(GROUND_Y));
`else
    e.miss = 1'b0;
`endif
    e.kill = e.hit || e.miss;
    if (m_armed) begin
      if (e.hit) begin
        m_armed  = 1'b0;
        m_ignore = (LOCK == 0) ? 1 : LOCK;
        m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end
    end else begin
      m_ignore = m_ignore - 1;
      if (m_ignore == 0) m_armed = 1'b1;
    end
    e.cnt = m_cnt;
    e.lck = !m_armed;
  endtask

  // Monitor: recognises ticks on its own and checks the DUT two cycles later.
  bit vprev = 1'b0, d1 = 1'b0, d2 = 1'b0, rst_last = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    bit   t;
    bit   miss_act;
`ifdef DOG_HIT_MISS_REPORT_EN
    miss_act = proj_miss;
`else
    miss_act = 1'b0;
`endif
    if (rst_last) begin
      vectors++;
      if (hit_dog !== 1'b0 || proj_kill !== 1'b0 || hit_count !== '0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL reset_vals: hit=%b kill=%b cnt=%0d locked=%b, required 0 0 0 0",
                 hit_dog, proj_kill, hit_count, locked);
      end
    end
    if (rst) begin
      vprev = 1'b0;
      d1    = 1'b0;
      d2    = 1'b0;
    end else begin
      t = vblnk & ~vprev;
      vprev = vblnk;
      if (d2) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_resp: no expectation queued at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          if (hit_dog !== e.hit || proj_kill !== e.kill || miss_act !== e.miss ||
              hit_count !== CW'(e.cnt) || locked !== e.lck) begin
            errors++;
            $display("FAIL tick_resp t=%0t: hit=%b kill=%b miss=%b cnt=%0d locked=%b, required hit=%b kill=%b miss=%b cnt=%0d locked=%b",
                     $time, hit_dog, proj_kill, miss_act, hit_count, locked,
                     e.hit, e.kill, e.miss, e.cnt, e.lck);
          end
        end
      end else if (!rst_last) begin
        vectors++;
        if (hit_dog !== 1'b0 || proj_kill !== 1'b0 || miss_act !== 1'b0) begin
          errors++;
          $display("FAIL stray_pulse t=%0t: hit=%b kill=%b miss=%b, required 0 0 0",
                   $time, hit_dog, proj_kill, miss_act);
        end
      end
      d2 = d1;
      d1 = t;
    end
    rst_last = rst;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst   = 1'b1;
    vblnk = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  // One frame: inputs held through the tick cycle, then scrambled while vblnk stays high.
  task automatic frame(input int px, input int py, input bit v);
    exp_t e;
    cyc();
    proj_x     = 11'(px);
    proj_y     = 11'(py);
    proj_valid = v;
    vblnk      = 1'b0;
    repeat (5) cyc();
    vblnk = 1'b1;
    model_tick(px, py, v, e);
    exp_q.push_back(e);
    cyc();
    if ($urandom_range(0, 1) == 1) begin
      proj_x = 11'd900; proj_y = 11'd450; proj_valid = 1'b1;
    end else begin
      proj_x = 11'($urandom); proj_y = 11'($urandom); proj_valid = 1'($urandom);
    end
    repeat (3) cyc();
  endtask

  // Tick issued, then reset lands before the hit pulse would appear.
  task automatic pipe_reset();
    cyc();
    proj_x = 11'd900; proj_y = 11'd450; proj_valid = 1'b1; vblnk = 1'b0;
    repeat (4) cyc();
    vblnk = 1'b1;
    cyc();
    rst   = 1'b1;
    vblnk = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int px, py;
    rst = 1'b1; vblnk = 1'b0; proj_x = '0; proj_y = '0; proj_valid = 1'b0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;

    frame(900, 450, 1);
    repeat (35) frame(900, 450, 1);

    do_reset();
    frame(900, 450, 1);
    frame(900, 450, 1);

    do_reset(); frame(856, 450, 1); frame(1020, 450, 1); frame(857, 450, 1);
    do_reset(); frame(900, 406, 1); frame(900, 581, 1); frame(900, 407, 1);
    do_reset(); frame(1019, 580, 1);
    do_reset(); frame(900, 450, 0); frame(900, 450, 1);

    pipe_reset();
    frame(900, 450, 1);

`ifdef DOG_HIT_MISS_REPORT_EN
    do_reset(); frame(100, 570, 1); frame(100, 570, 0); frame(900, 450, 1); frame(100, 600, 1);
`endif

    do_reset();
    repeat (16 * (LOCK + 1) + 35) frame(900, 450, 1);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      px = ($urandom_range(0, 1) == 1) ? int'($urandom_range(840, 1040)) : int'($urandom_range(0, 2047));
      py = ($urandom_range(0, 1) == 1) ? int'($urandom_range(390, 620))  : int'($urandom_range(0, 2047));
      frame(px, py, ($urandom_range(0, 3) != 0));
    end

    repeat (4) cyc();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
